// File: rtl/booth_mul_scheduler_pkg.sv
// Shared widths and types for the Booth multiplier scheduler and its core.
// No logic here; latency and backpressure live in booth_mul_scheduler.
package booth_mul_scheduler_pkg;

   localparam int XW       = 16;
   localparam int PW       = 32;
   localparam int NREQ_DEF = 4;

   function automatic int id_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   localparam int IDW_DEF = id_width(NREQ_DEF);

   typedef struct packed {
      logic [XW-1:0] x;
      logic [XW-1:0] y;
   } opnd_t;

endpackage

// File: rtl/booth_mul_scheduler_booth.sv
// Combinational radix-4 Booth multiplier, signed XW x XW -> PW.
// Zero latency, no handshake; the scheduler registers its inputs and output.
module BoothMultiplier
   import booth_mul_scheduler_pkg::*;
(
   input  logic [XW-1:0] a_i,
   input  logic [XW-1:0] b_i,
   output logic [PW-1:0] p_o
);

   logic [PW-1:0] a_ext;
   logic [PW-1:0] pp;
   logic [PW-1:0] acc;
   logic [XW:0]   b_ext;
   logic [2:0]    grp;

   always_comb begin
      a_ext = {{(PW-XW){a_i[XW-1]}}, a_i};
      b_ext = {b_i, 1'b0};
      acc   = '0;
      pp    = '0;
      grp   = '0;
      // Recoded digit per bit pair is in {-2,-1,0,+1,+2}; all arithmetic wraps mod 2^PW.
      for (int i = 0; i < XW/2; i++) begin
         grp = b_ext[2*i +: 3];
         case (grp)
            3'b001, 3'b010: pp = a_ext;
            3'b011:         pp = a_ext << 1;
            3'b100:         pp = -(a_ext << 1);
            3'b101, 3'b110: pp = -a_ext;
            default:        pp = '0;
         endcase
         acc = acc + (pp << (2*i));
      end
      p_o = acc;
   end

endmodule

// File: rtl/booth_mul_scheduler_rr_arbiter.sv
// Round-robin arbiter: grants the first active request at or above the pointer.
// Purely combinational, zero latency; the caller masks the grant under backpressure.
module rr_arbiter #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic [NREQ-1:0] req_i,
   input  logic [IDW-1:0]  pointer_i,
   output logic [NREQ-1:0] grant_onehot_o,
   output logic [IDW-1:0]  grant_idx_o
);

   logic found;
   int   idx;

   always_comb begin
      grant_onehot_o = '0;
      grant_idx_o    = '0;
      found          = 1'b0;
      idx            = 0;
      for (int off = 0; off < NREQ; off++) begin
         idx = (int'(pointer_i) + off) % NREQ;
         if (!found && req_i[idx]) begin
            found               = 1'b1;
            grant_onehot_o[idx] = 1'b1;
            grant_idx_o         = IDW'(idx);
         end
      end
   end

endmodule

// File: rtl/booth_mul_scheduler.sv
// Round-robin shares one Booth multiplier among NREQ clients; 2-cycle latency, 1 op/cycle.
// A stalled response (rsp_valid & ~rsp_ready) freezes both stages and withholds all grants.
module booth_mul_scheduler
   import booth_mul_scheduler_pkg::*;
#(
   parameter int NREQ = NREQ_DEF,
   parameter int IDW  = id_width(NREQ),
   parameter int CNTW = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [NREQ*XW-1:0] req_x,
   input  logic [NREQ*XW-1:0] req_y,
   output logic [NREQ-1:0]   req_ready,
   output logic              rsp_valid,
   output logic [PW-1:0]     rsp_data,
   output logic [IDW-1:0]    rsp_id,
   input  logic              rsp_ready,
   output logic              busy,
   output logic [CNTW-1:0]   op_count
);

   logic            advance;
   logic            hs;
   logic [NREQ-1:0] grant;
   logic [IDW-1:0]  grant_idx;
   opnd_t           sel;
   logic [PW-1:0]   prod;

   opnd_t           s1_q, s1_d;
   logic [IDW-1:0]  s1_id_q, s1_id_d;
   logic            s1_valid_q, s1_valid_d;
   logic [PW-1:0]   rsp_data_q, rsp_data_d;
   logic [IDW-1:0]  rsp_id_q, rsp_id_d;
   logic            rsp_valid_q, rsp_valid_d;
   logic [IDW-1:0]  ptr_q, ptr_d;
   logic [CNTW-1:0] cnt_q, cnt_d;

   rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
      .req_i          (req_valid),
      .pointer_i      (ptr_q),
      .grant_onehot_o (grant),
      .grant_idx_o    (grant_idx)
   );

   BoothMultiplier u_core (
      .a_i (s1_q.x),
      .b_i (s1_q.y),
      .p_o (prod)
   );

   assign advance   = ~rsp_valid_q | rsp_ready;
   assign req_ready = advance ? grant : '0;
   assign hs        = |(req_valid & req_ready);

   always_comb begin
      sel = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant[i]) begin
            sel.x = req_x[i*XW +: XW];
            sel.y = req_y[i*XW +: XW];
         end
      end
   end

   always_comb begin
      s1_d        = s1_q;
      s1_id_d     = s1_id_q;
      s1_valid_d  = s1_valid_q;
      rsp_data_d  = rsp_data_q;
      rsp_id_d    = rsp_id_q;
      rsp_valid_d = rsp_valid_q;
      ptr_d       = ptr_q;
      cnt_d       = cnt_q;
      if (advance) begin
         rsp_data_d  = prod;
         rsp_id_d    = s1_id_q;
         rsp_valid_d = s1_valid_q;
         s1_valid_d  = hs;
         if (hs) begin
            s1_d    = sel;
            s1_id_d = grant_idx;
         end
      end
      if (hs) begin
         ptr_d = (grant_idx == IDW'(NREQ-1)) ? '0 : grant_idx + IDW'(1);
      end
      if (rsp_valid_q && rsp_ready) begin
         cnt_d = cnt_q + CNTW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_q        <= '0;
         s1_id_q     <= '0;
         s1_valid_q  <= 1'b0;
         rsp_data_q  <= '0;
         rsp_id_q    <= '0;
         rsp_valid_q <= 1'b0;
         ptr_q       <= '0;
         cnt_q       <= '0;
      end else begin
         s1_q        <= s1_d;
         s1_id_q     <= s1_id_d;
         s1_valid_q  <= s1_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_id_q    <= rsp_id_d;
         rsp_valid_q <= rsp_valid_d;
         ptr_q       <= ptr_d;
         cnt_q       <= cnt_d;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_id    = rsp_id_q;
   assign busy      = s1_valid_q | rsp_valid_q;
   assign op_count  = cnt_q;

endmodule

// File: tb/tb_booth_mul_scheduler.sv
// Directed table-driven bench for booth_mul_scheduler plus reset and counter-wrap sequences.
// Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
module tb_booth_mul_scheduler;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req_valid;
   logic [63:0] req_x;
   logic [63:0] req_y;
   logic [3:0]  req_ready;
   logic        rsp_valid;
   logic [31:0] rsp_data;
   logic [1:0]  rsp_id;
   logic        rsp_ready;
   logic        busy;
   logic [15:0] op_count;

   logic [3:0]  req_ready4;
   logic        rsp_valid4;
   logic [31:0] rsp_data4;
   logic [1:0]  rsp_id4;
   logic        busy4;
   logic [3:0]  op_count4;

   int vec_cnt = 0;
   int err_cnt = 0;

   always #5 clk = ~clk;

   booth_mul_scheduler #(.NREQ(4), .IDW(2), .CNTW(16)) u_dut (
      .clk (clk), .rst (rst),
      .req_valid (req_valid), .req_x (req_x), .req_y (req_y), .req_ready (req_ready),
      .rsp_valid (rsp_valid), .rsp_data (rsp_data), .rsp_id (rsp_id), .rsp_ready (rsp_ready),
      .busy (busy), .op_count (op_count)
   );

   booth_mul_scheduler #(.NREQ(4), .IDW(2), .CNTW(4)) u_dut4 (
      .clk (clk), .rst (rst),
      .req_valid (req_valid), .req_x (req_x), .req_y (req_y), .req_ready (req_ready4),
      .rsp_valid (rsp_valid4), .rsp_data (rsp_data4), .rsp_id (rsp_id4), .rsp_ready (rsp_ready),
      .busy (busy4), .op_count (op_count4)
   );

   typedef struct {
      logic [3:0]  vld;
      logic [63:0] x;
      logic [63:0] y;
      logic        rdy;
      logic [3:0]  rr;
      logic        rv;
      logic [31:0] data;
      logic [1:0]  id;
      logic        bsy;
      logic [15:0] cnt;
   } vec_t;

   vec_t tbl[$];

   function automatic logic [63:0] sx(input int i, input logic [15:0] v);
      return 64'(v) << (16*i);
   endfunction

   task automatic add(input logic [3:0] vld, input logic [63:0] x, input logic [63:0] y,
                      input logic rdy, input logic [3:0] rr, input logic rv,
                      input logic [31:0] data, input logic [1:0] id, input logic bsy,
                      input logic [15:0] cnt);
      vec_t v;
      v.vld = vld; v.x = x; v.y = y; v.rdy = rdy; v.rr = rr;
      v.rv = rv; v.data = data; v.id = id; v.bsy = bsy; v.cnt = cnt;
      tbl.push_back(v);
   endtask

   task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s[%0d] got %h want %h", nm, idx, act, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   logic [63:0] rot_x, y10, y100, xb, yb;
   logic        exp_v;

   initial begin
      rot_x = {16'd3, 16'd2, 16'd1, 16'd0};
      y10   = {4{16'd10}};
      y100  = sx(1, 16'd100);
      xb    = sx(1, 16'd3) | sx(3, 16'd7);
      yb    = sx(1, 16'd100) | sx(3, 16'd7);

      // Rotation with all four requesters valid, pointer starting at 0.
      add(4'hF, rot_x, y10, 1'b1, 4'b0001, 1'b0, 32'd0,  2'd0, 1'b0, 16'd0);
      add(4'hF, rot_x, y10, 1'b1, 4'b0010, 1'b0, 32'd0,  2'd0, 1'b1, 16'd0);
      add(4'hF, rot_x, y10, 1'b1, 4'b0100, 1'b1, 32'd0,  2'd0, 1'b1, 16'd0);
      add(4'hF, rot_x, y10, 1'b1, 4'b1000, 1'b1, 32'd10, 2'd1, 1'b1, 16'd1);
      add(4'hF, rot_x, y10, 1'b1, 4'b0001, 1'b1, 32'd20, 2'd2, 1'b1, 16'd2);
      add(4'hF, rot_x, y10, 1'b1, 4'b0010, 1'b1, 32'd30, 2'd3, 1'b1, 16'd3);
      add(4'hF, rot_x, y10, 1'b1, 4'b0100, 1'b1, 32'd0,  2'd0, 1'b1, 16'd4);
      add(4'hF, rot_x, y10, 1'b1, 4'b1000, 1'b1, 32'd10, 2'd1, 1'b1, 16'd5);
      add(4'h0, 64'd0, 64'd0, 1'b1, 4'b0000, 1'b1, 32'd20, 2'd2, 1'b1, 16'd6);
      add(4'h0, 64'd0, 64'd0, 1'b1, 4'b0000, 1'b1, 32'd30, 2'd3, 1'b1, 16'd7);
      add(4'h0, 64'd0, 64'd0, 1'b1, 4'b0000, 1'b0, 32'd0,  2'd0, 1'b0, 16'd8);
      // Single op from requester 2: 3*5.
      add(4'b0100, sx(2, 16'd3), sx(2, 16'd5), 1'b1, 4'b0100, 1'b0, 32'd0, 2'd0, 1'b0, 16'd8);
      add(4'h0, 64'd0, 64'd0, 1'b1, 4'b0000, 1'b0, 32'd0,  2'd0, 1'b1, 16'd8);
      add(4'h0, 64'd0, 64'd0, 1'b1, 4'b0000, 1'b1, 32'hF,  2'd2, 1'b1, 16'd8);
      add(4'h0, 64'd0, 64'd0, 1'b1, 4'b0000, 1'b0, 32'd0,  2'd0, 1'b0, 16'd9);
      // Signed corners back-to-back from requester 0.
      add(4'b0001, sx(0, 16'hFFFE), sx(0, 16'd7),   1'b1, 4'b0001, 1'b0, 32'd0, 2'd0, 1'b0, 16'd9);
      add(4'b0001, sx(0, 16'h8000), sx(0, 16'h8000), 1'b1, 4'b0001, 1'b0, 32'd0, 2'd0, 1'b1, 16'd9);
      add(4'b0001, sx(0, 16'h7FFF), sx(0, 16'h8000), 1'b1, 4'b0001, 1'b1, 32'hFFFFFFF2, 2'd0, 1'b1, 16'd9);
      add(4'b0001, sx(0, 16'hFFFF), sx(0, 16'hFFFF), 1'b1, 4'b0001, 1'b1, 32'h40000000, 2'd0, 1'b1, 16'd10);
      add(4'h0, 64'd0, 64'd0, 1'b1, 4'b0000, 1'b1, 32'hC0008000, 2'd0, 1'b1, 16'd11);
      add(4'h0, 64'd0, 64'd0, 1'b1, 4'b0000, 1'b1, 32'h00000001, 2'd0, 1'b1, 16'd12);
      add(4'h0, 64'd0, 64'd0, 1'b1, 4'b0000, 1'b0, 32'd0, 2'd0, 1'b0, 16'd13);
      // Five ops from requester 1 with a 4-cycle response stall; requester 3 gives up while stalled.
      add(4'b0010, sx(1, 16'd1), y100, 1'b1, 4'b0010, 1'b0, 32'd0,   2'd0, 1'b0, 16'd13);
      add(4'b0010, sx(1, 16'd2), y100, 1'b1, 4'b0010, 1'b0, 32'd0,   2'd0, 1'b1, 16'd13);
      add(4'b1010, xb, yb,             1'b0, 4'b0000, 1'b1, 32'd100, 2'd1, 1'b1, 16'd13);
      add(4'b1010, xb, yb,             1'b0, 4'b0000, 1'b1, 32'd100, 2'd1, 1'b1, 16'd13);
      add(4'b0010, sx(1, 16'd3), y100, 1'b0, 4'b0000, 1'b1, 32'd100, 2'd1, 1'b1, 16'd13);
      add(4'b0010, sx(1, 16'd3), y100, 1'b0, 4'b0000, 1'b1, 32'd100, 2'd1, 1'b1, 16'd13);
      add(4'b0010, sx(1, 16'd3), y100, 1'b1, 4'b0010, 1'b1, 32'd100, 2'd1, 1'b1, 16'd13);
      add(4'b0010, sx(1, 16'd4), y100, 1'b1, 4'b0010, 1'b1, 32'd200, 2'd1, 1'b1, 16'd14);
      add(4'b0010, sx(1, 16'd5), y100, 1'b1, 4'b0010, 1'b1, 32'd300, 2'd1, 1'b1, 16'd15);
      add(4'h0, 64'd0, 64'd0, 1'b1, 4'b0000, 1'b1, 32'd400, 2'd1, 1'b1, 16'd16);
      add(4'h0, 64'd0, 64'd0, 1'b1, 4'b0000, 1'b1, 32'd500, 2'd1, 1'b1, 16'd17);
      add(4'h0, 64'd0, 64'd0, 1'b1, 4'b0000, 1'b0, 32'd0,   2'd0, 1'b0, 16'd18);

      // Reset state.
      rst = 1'b1; req_valid = '0; req_x = '0; req_y = '0; rsp_ready = 1'b1;
      #2;
      chk("rst_rsp_valid", 0, 32'(rsp_valid), 32'd0);
      chk("rst_rsp_data",  0, rsp_data,       32'd0);
      chk("rst_rsp_id",    0, 32'(rsp_id),    32'd0);
      chk("rst_busy",      0, 32'(busy),      32'd0);
      chk("rst_op_count",  0, 32'(op_count),  32'd0);
      next_cycle();
      rst = 1'b0;

      for (int i = 0; i < tbl.size(); i++) begin
         req_valid = tbl[i].vld;
         req_x     = tbl[i].x;
         req_y     = tbl[i].y;
         rsp_ready = tbl[i].rdy;
         @(negedge clk);
         chk("req_ready", i, 32'(req_ready), 32'(tbl[i].rr));
         chk("rsp_valid", i, 32'(rsp_valid), 32'(tbl[i].rv));
         chk("busy",      i, 32'(busy),      32'(tbl[i].bsy));
         chk("op_count",  i, 32'(op_count),  32'(tbl[i].cnt));
         if (tbl[i].rv) begin
            chk("rsp_data", i, rsp_data,     tbl[i].data);
            chk("rsp_id",   i, 32'(rsp_id),  32'(tbl[i].id));
         end
         next_cycle();
      end

      // Mid-stream asynchronous reset with two operations in flight (pointer is 2 here).
      rsp_ready = 1'b1;
      req_valid = 4'b0001; req_x = sx(0, 16'd2); req_y = sx(0, 16'd3);
      @(negedge clk);
      chk("mr_grant0", 0, 32'(req_ready), 32'h1);
      next_cycle();
      req_x = sx(0, 16'd4);
      @(negedge clk);
      chk("mr_grant1", 0, 32'(req_ready), 32'h1);
      next_cycle();
      req_valid = '0;
      #1;
      chk("mr_inflight_v", 0, 32'(rsp_valid), 32'd1);
      chk("mr_inflight_d", 0, rsp_data,       32'd6);
      #1;
      rst = 1'b1;
      #1;
      chk("mr_rsp_valid", 0, 32'(rsp_valid), 32'd0);
      chk("mr_rsp_data",  0, rsp_data,       32'd0);
      chk("mr_rsp_id",    0, 32'(rsp_id),    32'd0);
      chk("mr_busy",      0, 32'(busy),      32'd0);
      chk("mr_op_count",  0, 32'(op_count),  32'd0);
      next_cycle();
      rst = 1'b0;
      req_valid = 4'b1001;
      @(negedge clk);
      chk("mr_ptr_zero", 0, 32'(req_ready), 32'h1);
      chk("mr_no_stale", 0, 32'(rsp_valid), 32'd0);
      req_valid = '0;
      next_cycle();
      req_valid = 4'b0010; req_x = sx(1, 16'hFFFD); req_y = sx(1, 16'd9);
      @(negedge clk);
      chk("mr_grant_r1", 0, 32'(req_ready), 32'h2);
      chk("mr_no_stale", 1, 32'(rsp_valid), 32'd0);
      next_cycle();
      req_valid = '0;
      @(negedge clk);
      chk("mr_no_stale", 2, 32'(rsp_valid), 32'd0);
      chk("mr_busy_s1",  0, 32'(busy),      32'd1);
      next_cycle();
      @(negedge clk);
      chk("mr_r1_valid", 0, 32'(rsp_valid), 32'd1);
      chk("mr_r1_data",  0, rsp_data,       32'hFFFFFFE5);
      chk("mr_r1_id",    0, 32'(rsp_id),    32'd1);
      next_cycle();
      @(negedge clk);
      chk("mr_r1_done",  0, 32'(rsp_valid), 32'd0);
      chk("mr_r1_count", 0, 32'(op_count),  32'd1);
      next_cycle();

      // 17 ops through both builds; the 4-bit counter wraps to 1.
      rst = 1'b1;
      next_cycle();
      rst = 1'b0;
      for (int c = 0; c < 20; c++) begin
         req_valid = (c < 17) ? 4'b0001 : 4'b0000;
         req_x     = sx(0, 16'(c + 1));
         req_y     = sx(0, 16'd2);
         @(negedge clk);
         chk("w_req_ready", c, 32'(req_ready4), (c < 17) ? 32'h1 : 32'h0);
         if (c >= 2) begin
            exp_v = (c - 2) < 17;
            chk("w_rsp_valid", c, 32'(rsp_valid4), 32'(exp_v));
            if (exp_v) begin
               chk("w_rsp_data", c, rsp_data4,     32'(2 * (c - 1)));
               chk("w_rsp_id",   c, 32'(rsp_id4),  32'd0);
            end
         end
         next_cycle();
      end
      req_valid = '0;
      @(negedge clk);
      chk("w_op_count4",  0, 32'(op_count4), 32'd1);
      chk("w_op_count16", 0, 32'(op_count),  32'd17);
      chk("w_busy4",      0, 32'(busy4),     32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
